// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the UART calculator datapath.
//   - dtype codes, one-hot ALU op codes
//   - ASCII constants used by the command parser / result formatter
//   - parser state enum and small char-classification helpers
package calc_pkg;

  localparam logic [3:0] DT_UNSIGNED = 4'h1;
  localparam logic [3:0] DT_SIGNED   = 4'h2;

  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_MUL = 5'h04;
  localparam logic [4:0] OP_DIV = 5'h08;

  localparam logic [7:0] ASCII_W     = 8'h57;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SRC1  = 3'd1,
    ST_OPER  = 3'd2,
    ST_SRC2  = 3'd3,
    ST_TERM  = 3'd4,
    ST_ISSUE = 3'd5,
    ST_WAIT  = 3'd6
  } parser_state_t;

  // Type char to dtype code; 4'h0 means "not a type char".
  function automatic logic [3:0] dtype_from_char(input logic [7:0] c);
    logic [3:0] d;
    d = 4'h0;
    if (c == ASCII_W) d = DT_UNSIGNED;
    else if (c == ASCII_S) d = DT_SIGNED;
    return d;
  endfunction

  // Operator char to one-hot op code; 5'h00 means "not an operator".
  function automatic logic [4:0] op_from_char(input logic [7:0] c);
    logic [4:0] o;
    o = 5'h00;
    case (c)
      ASCII_PLUS:  o = OP_ADD;
      ASCII_MINUS: o = OP_SUB;
      ASCII_STAR:  o = OP_MUL;
      ASCII_SLASH: o = OP_DIV;
      default:     o = 5'h00;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// ascii_hex_decode: combinational ASCII hex digit decoder.
//   ascii  in  8 : byte to classify
//   valid  out 1 : byte is '0'-'9', 'A'-'F' or 'a'-'f'
//   nibble out 4 : digit value (0 when not valid)
module ascii_hex_decode (
  input  logic [7:0] ascii,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b0;
    nibble = 4'h0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      valid  = 1'b1;
      nibble = ascii[3:0];
    end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                 (ascii >= 8'h61 && ascii <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
      valid  = 1'b1;
      nibble = ascii[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/alu_cmd_parser.sv
// alu_cmd_parser: assembles "<type><4 hex><op><4 hex><CR>" frames from the
// UART receiver and issues them to the ALU.
//   clk, rst            : clock, synchronous active-high reset
//   rx_data, rx_valid   : received byte and its one-cycle strobe
//   alu_done            : one-cycle completion pulse from the ALU
//   dtype, op           : data type code and one-hot operator
//   src1, src2          : operands, held from start until after alu_done
//   start               : one-cycle issue pulse
//   busy                : high from start through the alu_done cycle
//   frame_err           : pulse when a frame is rejected
//   overrun             : pulse when a byte is dropped while busy
module alu_cmd_parser
  import calc_pkg::*;
#(
  parameter int HEX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        alu_done,
  output logic [3:0]  dtype,
  output logic [4:0]  op,
  output logic [15:0] src1,
  output logic [15:0] src2,
  output logic        start,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun
);

  // Counter value of the final digit of an operand.
  localparam logic [1:0] LAST_DIGIT = 2'(HEX_DIGITS - 1);

  parser_state_t state_reg, state_next;

  logic [1:0]  digit_cnt_reg, digit_cnt_next;
  logic [3:0]  sh_dtype_reg,  sh_dtype_next;
  logic [4:0]  sh_op_reg,     sh_op_next;
  logic [15:0] sh_src1_reg,   sh_src1_next;
  logic [15:0] sh_src2_reg,   sh_src2_next;

  logic [3:0]  dtype_reg,     dtype_next;
  logic [4:0]  op_reg,        op_next;
  logic [15:0] src1_reg,      src1_next;
  logic [15:0] src2_reg,      src2_next;
  logic        start_reg,     start_next;
  logic        busy_reg,      busy_next;
  logic        frame_err_reg, frame_err_next;
  logic        overrun_reg,   overrun_next;

  logic        hex_valid;
  logic [3:0]  hex_nibble;
  logic [3:0]  rx_dtype;
  logic [4:0]  rx_op;
  logic        last_digit;

  ascii_hex_decode u_hex (
    .ascii  (rx_data),
    .valid  (hex_valid),
    .nibble (hex_nibble)
  );

  assign rx_dtype   = dtype_from_char(rx_data);
  assign rx_op      = op_from_char(rx_data);
  assign last_digit = (digit_cnt_reg == LAST_DIGIT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        // Non-type bytes are line noise between frames: ignore quietly.
        if (rx_valid && rx_dtype != 4'h0) state_next = ST_SRC1;
      end
      ST_SRC1: begin
        if (rx_valid) begin
          if (!hex_valid)      state_next = ST_IDLE;
          else if (last_digit) state_next = ST_OPER;
        end
      end
      ST_OPER: begin
        if (rx_valid) state_next = (rx_op != 5'h00) ? ST_SRC2 : ST_IDLE;
      end
      ST_SRC2: begin
        if (rx_valid) begin
          if (!hex_valid)      state_next = ST_IDLE;
          else if (last_digit) state_next = ST_TERM;
        end
      end
      ST_TERM: begin
        if (rx_valid) state_next = (rx_data == ASCII_CR) ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (alu_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output / datapath logic: every output is produced as a _next value and
  // registered, so no input reaches an output combinationally.
  always_comb begin
    digit_cnt_next = digit_cnt_reg;
    sh_dtype_next  = sh_dtype_reg;
    sh_op_next     = sh_op_reg;
    sh_src1_next   = sh_src1_reg;
    sh_src2_next   = sh_src2_reg;
    dtype_next     = dtype_reg;
    op_next        = op_reg;
    src1_next      = src1_reg;
    src2_next      = src2_reg;

    start_next     = (state_reg == ST_TERM) && (state_next == ST_ISSUE);
    busy_next      = (state_next == ST_ISSUE) || (state_next == ST_WAIT);
    overrun_next   = rx_valid && ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT));
    frame_err_next = rx_valid && (state_next == ST_IDLE) &&
                     ((state_reg == ST_SRC1) || (state_reg == ST_OPER) ||
                      (state_reg == ST_SRC2) || (state_reg == ST_TERM));

    case (state_reg)
      ST_IDLE: begin
        if (rx_valid && rx_dtype != 4'h0) begin
          sh_dtype_next  = rx_dtype;
          sh_op_next     = 5'h00;
          sh_src1_next   = 16'h0000;
          sh_src2_next   = 16'h0000;
          digit_cnt_next = 2'd0;
        end
      end
      ST_SRC1: begin
        if (rx_valid && hex_valid) begin
          sh_src1_next   = {sh_src1_reg[11:0], hex_nibble};
          digit_cnt_next = digit_cnt_reg + 2'd1;
        end
      end
      ST_OPER: begin
        if (rx_valid && rx_op != 5'h00) sh_op_next = rx_op;
      end
      ST_SRC2: begin
        if (rx_valid && hex_valid) begin
          sh_src2_next   = {sh_src2_reg[11:0], hex_nibble};
          digit_cnt_next = digit_cnt_reg + 2'd1;
        end
      end
      default: ;
    endcase

    // A rejected frame leaves nothing behind in the assembly registers.
    if (frame_err_next) begin
      sh_dtype_next  = 4'h0;
      sh_op_next     = 5'h00;
      sh_src1_next   = 16'h0000;
      sh_src2_next   = 16'h0000;
      digit_cnt_next = 2'd0;
    end

    // ALU-facing registers change only at issue and then hold through WAIT.
    if (start_next) begin
      dtype_next = sh_dtype_reg;
      op_next    = sh_op_reg;
      src1_next  = sh_src1_reg;
      src2_next  = sh_src2_reg;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_cnt_reg <= 2'd0;
      sh_dtype_reg  <= 4'h0;
      sh_op_reg     <= 5'h00;
      sh_src1_reg   <= 16'h0000;
      sh_src2_reg   <= 16'h0000;
      dtype_reg     <= 4'h0;
      op_reg        <= 5'h00;
      src1_reg      <= 16'h0000;
      src2_reg      <= 16'h0000;
      start_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      digit_cnt_reg <= digit_cnt_next;
      sh_dtype_reg  <= sh_dtype_next;
      sh_op_reg     <= sh_op_next;
      sh_src1_reg   <= sh_src1_next;
      sh_src2_reg   <= sh_src2_next;
      dtype_reg     <= dtype_next;
      op_reg        <= op_next;
      src1_reg      <= src1_next;
      src2_reg      <= src2_next;
      start_reg     <= start_next;
      busy_reg      <= busy_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign dtype     = dtype_reg;
  assign op        = op_reg;
  assign src1      = src1_reg;
  assign src2      = src2_reg;
  assign start     = start_reg;
  assign busy      = busy_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_alu_cmd_parser.sv
// Self-checking bench for alu_cmd_parser: directed scenarios from the frame
// rules plus randomized frames (some corrupted) checked against a model that
// derives expected outputs directly from the frame contents.
module tb_alu_cmd_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        alu_done;
  logic [3:0]  dtype;
  logic [4:0]  op;
  logic [15:0] src1;
  logic [15:0] src2;
  logic        start;
  logic        busy;
  logic        frame_err;
  logic        overrun;

  int vectors     = 0;
  int miscompares = 0;
  int start_cnt   = 0;
  int ferr_cnt    = 0;
  int ovr_cnt     = 0;

  // Model of the last issued command (what the ALU-facing outputs must hold).
  logic [40:0] exp_out;

  always #5 clk = ~clk;

  alu_cmd_parser #(.HEX_DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .alu_done  (alu_done),
    .dtype     (dtype),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .start     (start),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (start)     start_cnt++;
    if (frame_err) ferr_cnt++;
    if (overrun)   ovr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic pulse_done();
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return (lower ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
  endfunction

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; alu_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({dtype, op, src1, src2} !== 41'h0) begin
      miscompares++;
      $display("FAIL reset_data got=%h want=0", {dtype, op, src1, src2});
    end
    vectors++;
    if ({start, busy, frame_err, overrun} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags got=%b want=0000", {start, busy, frame_err, overrun});
    end
    exp_out = 41'h0;
    $display("test_reset done");
  endtask

  task automatic test_unsigned_add();
    int s0;
    s0 = start_cnt;
    send_str("W00FF+0001");
    send_byte(8'h0D);
    exp_out = {4'h1, 5'h01, 16'h00FF, 16'h0001};
    vectors++;
    if ({start, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL add_start_busy got=%b want=11", {start, busy});
    end
    vectors++;
    if ({dtype, op, src1, src2} !== exp_out) begin
      miscompares++;
      $display("FAIL add_outputs got=%h want=%h", {dtype, op, src1, src2}, exp_out);
    end
    repeat (3) tick();
    vectors++;
    if ({start, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL add_wait_busy got=%b want=01", {start, busy});
    end
    pulse_done();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL add_busy_clear got=%b want=0", busy);
    end
    vectors++;
    if ({dtype, op, src1, src2} !== exp_out) begin
      miscompares++;
      $display("FAIL add_hold_after_done got=%h want=%h", {dtype, op, src1, src2}, exp_out);
    end
    tick();
    vectors++;
    if (start_cnt - s0 !== 1) begin
      miscompares++;
      $display("FAIL add_start_count got=%0d want=1", start_cnt - s0);
    end
    $display("test_unsigned_add frame W00FF+0001 done");
  endtask

  task automatic test_signed_div();
    send_str("Sfff6/0003");
    vectors++;
    if (start !== 1'b0) begin
      miscompares++;
      $display("FAIL div_early_start got=%b want=0", start);
    end
    send_byte(8'h0D);
    exp_out = {4'h2, 5'h08, 16'hFFF6, 16'h0003};
    vectors++;
    if ({start, {dtype, op, src1, src2}} !== {1'b1, exp_out}) begin
      miscompares++;
      $display("FAIL div_issue got=%b/%h want=1/%h", start, {dtype, op, src1, src2}, exp_out);
    end
    tick();
    pulse_done();
    $display("test_signed_div frame Sfff6/0003 done");
  endtask

  task automatic test_bad_operator();
    int s0, f0;
    s0 = start_cnt; f0 = ferr_cnt;
    send_str("W0001");
    send_byte(8'h78);
    vectors++;
    if (frame_err !== 1'b1) begin
      miscompares++;
      $display("FAIL badop_frame_err got=%b want=1", frame_err);
    end
    tick();
    vectors++;
    if ({frame_err, start, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL badop_after got=%b want=000", {frame_err, start, busy});
    end
    vectors++;
    if ({dtype, op, src1, src2} !== exp_out) begin
      miscompares++;
      $display("FAIL badop_outputs_kept got=%h want=%h", {dtype, op, src1, src2}, exp_out);
    end
    send_str("W0002*0003");
    send_byte(8'h0D);
    exp_out = {4'h1, 5'h04, 16'h0002, 16'h0003};
    vectors++;
    if ({start, {dtype, op, src1, src2}} !== {1'b1, exp_out}) begin
      miscompares++;
      $display("FAIL badop_next_issue got=%b/%h want=1/%h", start, {dtype, op, src1, src2}, exp_out);
    end
    tick();
    pulse_done();
    tick();
    vectors++;
    if ({ferr_cnt - f0, start_cnt - s0} !== {32'd1, 32'd1}) begin
      miscompares++;
      $display("FAIL badop_counts got=%0d/%0d want=1/1", ferr_cnt - f0, start_cnt - s0);
    end
    $display("test_bad_operator done");
  endtask

  task automatic test_overrun();
    int o0, f0;
    send_str("W1111-2222");
    send_byte(8'h0D);
    exp_out = {4'h1, 5'h02, 16'h1111, 16'h2222};
    o0 = ovr_cnt; f0 = ferr_cnt;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      vectors++;
      if ({overrun, busy, {dtype, op, src1, src2}} !== {2'b11, exp_out}) begin
        miscompares++;
        $display("FAIL overrun_byte%0d got=%b%b/%h want=11/%h", i, overrun, busy,
                 {dtype, op, src1, src2}, exp_out);
      end
    end
    // Byte coincident with alu_done: done wins, byte still dropped.
    rx_data = 8'h57; rx_valid = 1'b1; alu_done = 1'b1;
    tick();
    rx_valid = 1'b0; alu_done = 1'b0; rx_data = 8'h00;
    vectors++;
    if ({overrun, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL overrun_coincident got=%b want=10", {overrun, busy});
    end
    send_str("S0005+0006");
    send_byte(8'h0D);
    exp_out = {4'h2, 5'h01, 16'h0005, 16'h0006};
    vectors++;
    if ({start, {dtype, op, src1, src2}} !== {1'b1, exp_out}) begin
      miscompares++;
      $display("FAIL overrun_next_issue got=%b/%h want=1/%h", start, {dtype, op, src1, src2}, exp_out);
    end
    tick();
    pulse_done();
    tick();
    vectors++;
    if ({ovr_cnt - o0, ferr_cnt - f0} !== {32'd4, 32'd0}) begin
      miscompares++;
      $display("FAIL overrun_counts got=%0d/%0d want=4/0", ovr_cnt - o0, ferr_cnt - f0);
    end
    $display("test_overrun done");
  endtask

  task automatic test_reset_midframe();
    send_str("W12");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_out = 41'h0;
    vectors++;
    if ({dtype, op, src1, src2, start, busy, frame_err, overrun} !== 45'h0) begin
      miscompares++;
      $display("FAIL rstmid_outputs got=%h want=0", {dtype, op, src1, src2, start, busy, frame_err, overrun});
    end
    send_str("W1234-5678");
    send_byte(8'h0D);
    exp_out = {4'h1, 5'h02, 16'h1234, 16'h5678};
    vectors++;
    if ({start, {dtype, op, src1, src2}} !== {1'b1, exp_out}) begin
      miscompares++;
      $display("FAIL rstmid_issue got=%b/%h want=1/%h", start, {dtype, op, src1, src2}, exp_out);
    end
    tick();
    pulse_done();
    $display("test_reset_midframe done");
  endtask

  task automatic test_noise();
    int s0, f0;
    s0 = start_cnt; f0 = ferr_cnt;
    send_byte(8'h00);
    send_byte(8'h41);
    send_byte(8'h0D);
    send_str("S0000+0000");
    send_byte(8'h0D);
    exp_out = {4'h2, 5'h01, 16'h0000, 16'h0000};
    vectors++;
    if ({start, {dtype, op, src1, src2}} !== {1'b1, exp_out}) begin
      miscompares++;
      $display("FAIL noise_issue got=%b/%h want=1/%h", start, {dtype, op, src1, src2}, exp_out);
    end
    tick();
    pulse_done();
    tick();
    vectors++;
    if ({ferr_cnt - f0, start_cnt - s0} !== {32'd0, 32'd1}) begin
      miscompares++;
      $display("FAIL noise_counts got=%0d/%0d want=0/1", ferr_cnt - f0, start_cnt - s0);
    end
    $display("test_noise done");
  endtask

  // Random frames; about a quarter get one byte replaced by a char that is
  // illegal at every frame position past the type char.
  task automatic test_random_back_to_back();
    logic [7:0]  opch [4] = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};
    logic [7:0]  noise [4] = '{8'h00, 8'h41, 8'h0D, 8'h31};
    logic [7:0]  fr [11];
    logic [15:0] a, b;
    int opi, pos, nov, s0, f0, o0;
    bit signed_t, lower, corrupt;
    for (int k = 0; k < 24; k++) begin
      a = 16'($urandom); b = 16'($urandom);
      opi = $urandom_range(0, 3);
      signed_t = 1'($urandom); lower = 1'($urandom);
      corrupt = ($urandom_range(0, 3) == 0);
      pos = $urandom_range(1, 10);
      fr[0] = signed_t ? 8'h53 : 8'h57;
      for (int i = 0; i < 4; i++) begin
        fr[1 + i] = hex_char(a[4*(3-i) +: 4], lower);
        fr[6 + i] = hex_char(b[4*(3-i) +: 4], lower);
      end
      fr[5] = opch[opi];
      fr[10] = 8'h0D;
      s0 = start_cnt; f0 = ferr_cnt;
      if ($urandom_range(0, 1) == 1) send_byte(noise[$urandom_range(0, 3)]);
      if (corrupt) begin
        for (int i = 0; i < pos; i++) send_byte(fr[i]);
        send_byte(8'h78);
        vectors++;
        if (frame_err !== 1'b1) begin
          miscompares++;
          $display("FAIL rand%0d_frame_err pos=%0d got=%b want=1", k, pos, frame_err);
        end
        tick();
        vectors++;
        if ({ferr_cnt - f0, start_cnt - s0, {dtype, op, src1, src2}} !== {32'd1, 32'd0, exp_out}) begin
          miscompares++;
          $display("FAIL rand%0d_reject got=%0d/%0d/%h want=1/0/%h", k, ferr_cnt - f0,
                   start_cnt - s0, {dtype, op, src1, src2}, exp_out);
        end
        $display("rand %0d corrupt at %0d", k, pos);
      end else begin
        for (int i = 0; i < 11; i++) send_byte(fr[i]);
        exp_out = {signed_t ? 4'h2 : 4'h1, 5'(1 << opi), a, b};
        vectors++;
        if ({start, busy, {dtype, op, src1, src2}} !== {2'b11, exp_out}) begin
          miscompares++;
          $display("FAIL rand%0d_issue got=%b%b/%h want=11/%h", k, start, busy,
                   {dtype, op, src1, src2}, exp_out);
        end
        o0 = ovr_cnt;
        nov = $urandom_range(0, 3);
        for (int i = 0; i < nov; i++) send_byte(8'($urandom));
        tick();
        pulse_done();
        vectors++;
        if ({busy, {dtype, op, src1, src2}} !== {1'b0, exp_out}) begin
          miscompares++;
          $display("FAIL rand%0d_done got=%b/%h want=0/%h", k, busy, {dtype, op, src1, src2}, exp_out);
        end
        tick();
        vectors++;
        if ({ovr_cnt - o0, start_cnt - s0, ferr_cnt - f0} !== {nov, 32'd1, 32'd0}) begin
          miscompares++;
          $display("FAIL rand%0d_counts got=%0d/%0d/%0d want=%0d/1/0", k, ovr_cnt - o0,
                   start_cnt - s0, ferr_cnt - f0, nov);
        end
        $display("rand %0d issued %h", k, exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_add();
    test_signed_div();
    test_bad_operator();
    test_overrun();
    test_reset_midframe();
    test_noise();
    test_random_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_cmd_parser.md
# alu_cmd_parser

Upstream stage of the ALU in the UART calculator datapath. It consumes ASCII bytes from the UART receiver, assembles one calculation frame (data type, operand 1, operator, operand 2, terminator), and issues a single-cycle `start` with stable `dtype`/`op`/`src1`/`src2` to the ALU. It then holds those operands until `alu_done` returns. Malformed frames and bytes received while busy are discarded and flagged.

## Interface
- `HEX_DIGITS`, default 4: ASCII hex digits per operand. Fixed at 4 for 16-bit operands; any other value is unsupported.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in the same cycle.
- `alu_done` in 1: one-cycle completion pulse from the ALU.
- `dtype` out 4: 4'h1 unsigned, 4'h2 signed.
- `op` out 5: one-hot; add 5'h01, sub 5'h02, mul 5'h04, div 5'h08.
- `src1` out 16: operand 1.
- `src2` out 16: operand 2.
- `start` out 1: one-cycle issue pulse.
- `busy` out 1: high from `start` until `alu_done`, inclusive of the `start` cycle.
- `frame_err` out 1: one-cycle pulse when a frame is rejected.
- `overrun` out 1: one-cycle pulse when a byte is dropped while busy.

## Operation
- Frame format: type char, 4 hex digits, operator char, 4 hex digits, CR (8'h0D).
  - Type chars: 'W' (8'h57) gives dtype 4'h1; 'S' (8'h53) gives dtype 4'h2.
  - Operator chars: '+' 8'h2B, '-' 8'h2D, '*' 8'h2A, '/' 8'h2F.
  - Hex digits accepted: '0'-'9', 'A'-'F', 'a'-'f'. The first digit is the most significant nibble; each new digit shifts the operand left by 4 bits.
- States:
  - IDLE: waits for a type char. Any other byte is silently ignored; no error is raised, so line noise between frames is tolerated.
  - SRC1: collects 4 digits using a 2-bit digit counter. After the 4th digit, go to OPER.
  - OPER: waits for an operator char, then goes to SRC2.
  - SRC2: collects 4 digits, then goes to TERM.
  - TERM: waits for CR, then goes to ISSUE.
  - ISSUE: `start` = 1 for one cycle, then go to WAIT.
  - WAIT: stays until `alu_done`, then returns to IDLE.
- Invalid byte in SRC1, OPER, SRC2 or TERM: pulse `frame_err`, return to IDLE, and discard the partial operands. The offending byte is not re-examined as a type char.
- Output registers `dtype`/`op`/`src1`/`src2`:
  - Loaded only on the ISSUE transition, from shadow assembly registers.
  - Held constant through WAIT, because the ALU samples `dtype`/`op`/`src` combinationally after `start`.
  - Values keep their last contents after `alu_done`.
- `rx_valid` in ISSUE or WAIT: the byte is dropped and `overrun` pulses. A new frame can begin in the cycle after `alu_done`.
- `alu_done` outside WAIT is ignored.
- No range check on operands. Division by zero is passed through to the ALU.

## Timing
- Reset values: state IDLE; `dtype` 4'h0; `op` 5'h00; `src1`/`src2` 16'h0000; `start`, `busy`, `frame_err`, `overrun` all 0; shadow registers and digit counter all 0.
- Latency: the CR byte is accepted at edge N; `start` is high during cycle N+1; `busy` rises in the same cycle as `start`.
- Outputs become valid in the same cycle `start` is high, and stay stable until at least the cycle after `alu_done`.
- `busy` deasserts in the cycle after `alu_done` is sampled.
- `rx_valid` and `alu_done` in the same cycle during WAIT: `alu_done` takes priority (go to IDLE); the byte is dropped and `overrun` pulses.
- Reset mid-frame or during WAIT: immediately return to IDLE with all outputs at reset values. The next frame parses normally.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `calc_pkg` holds:
  - dtype codes (DT_UNSIGNED 4'h1, DT_SIGNED 4'h2).
  - op codes (OP_ADD, OP_SUB, OP_MUL, OP_DIV).
  - ASCII constants ('W', 'S', '+', '-', '*', '/', CR).
  - The state enum.
- One sub-module: `ascii_hex_decode`, combinational, byte in, `{valid, nibble[3:0]}` out. It is reused later by the TX result formatter.

## Test plan
- Unsigned add: send "W00FF+0001\r" → one `start` with dtype 4'h1, op 5'h01, src1 16'h00FF, src2 16'h0001, `busy` = 1. Then `alu_done` → `busy` = 0 the next cycle.
- Signed div, lowercase digits: send "Sfff6/0003\r" → dtype 4'h2, op 5'h08, src1 16'hFFF6, src2 16'h0003. `start` occurs exactly one cycle after the CR strobe.
- Bad operator: send "W0001x" → `frame_err` pulse, no `start`. Then "W0002*0003\r" → op 5'h04, src1 16'h0002, src2 16'h0003.
- Overrun: issue a frame, send 3 bytes before `alu_done` → 3 `overrun` pulses, outputs unchanged. Also drive `alu_done` coincident with a byte → IDLE and `overrun` in that cycle.
- Reset mid-frame: after "W12", assert `rst` for 1 cycle → all outputs 0. Then "W1234-5678\r" → op 5'h02, src1 16'h1234, src2 16'h5678.
- Noise in IDLE: send 8'h00, 'A', '\r' then "S0000+0000\r" → no `frame_err`, single `start` with dtype 4'h2.
